mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Controller plus iterative shift-add datapath for the RV32M multiply group (MUL, MULH, MULHSU, MULHU) in the 5-stage pipeline's EX stage.
- Accepts one request from EX and holds the pipeline stall while iterating.
- Presents a registered 32-bit result with a one-cycle done pulse, then returns to idle.
- Sign handling, zero fast-path and flush abort are included; DIV/REM funct3 codes are not accepted here.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX-stage request; sampled only in IDLE.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; bit2=1 is never accepted.
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value.
- flush  input  1  pipeline flush; aborts an in-flight operation.
- stall  output  1  holds IF/ID/EX while a multiply is pending.
- busy  output  1  state != IDLE (registered).
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  XLEN  registered product slice; holds its value until the next done.

Behaviour:
- Reset (rst=1 at a clk edge, from any state): state=IDLE, counter=0, internal registers=0, result=0, done=0, busy=0. stall=0 while rst is high.
- States: IDLE, CALC, DONE.
- Accept: accept = IDLE & start & ~funct3[2] & ~flush. stall = accept | (state==CALC), combinational, so the issuing instruction is frozen in its first cycle.
- Latch on accept:
  - mag_a = |op_a| if a is signed (funct3 001/010) and op_a[31]=1, else op_a.
  - mag_b = |op_b| if b is signed (funct3 001 only) and op_b[31]=1, else op_b.
  - neg = sign_a ^ sign_b; MUL treats both operands as unsigned.
  - Latch funct3, clear the 64-bit accumulator, counter=0.
- Zero fast path: if op_a==0 or op_b==0 at accept, go directly to DONE next cycle with product 0.
- Normal path: IDLE -> CALC.
- CALC, each cycle:
  - If mag_b[0]=1, acc[63:32] += mag_a, with carry kept in a 65th bit.
  - Shift {carry, acc} right by 1; shift mag_b right by 1; counter += 1.
  - When counter == XLEN-1 this cycle, next state is DONE.
  - Exactly XLEN CALC cycles.
- CALC -> DONE transition:
  - p = neg ? -acc : acc, in 64-bit two's complement.
  - result <= p[31:0] for MUL, otherwise p[63:32].
- DONE: done=1, stall=0, busy=1 for one cycle, then IDLE unconditionally. start during DONE is ignored; the dependent next instruction re-presents start in IDLE.
- Latency: accept at cycle T -> done at T+XLEN+1 (T+33). Zero fast path: done at T+1.
- Flush:
  - In IDLE, flush blocks accept.
  - In CALC, flush causes next state IDLE, counter=0, result unchanged, no done pulse, and stall drops in the cycle after flush.
  - In DONE, flush has no effect: done still pulses and the owner discards it.
- start with funct3[2]=1: ignored; no stall, state stays IDLE.
- Overflow: MUL wraps modulo 2^32. The most-negative case 0x80000000 x 0x80000000 requires magnitude 2^31, held as unsigned 32-bit, and must be exact.

Test Plan:
- Reset, then MUL 7 x 6 at cycle T -> stall high T..T+32, done at T+33, result=0x0000002A. stall=0 and done=0 afterwards.
- MULH / MULHU / MULHSU with op_a=op_b=0xFFFFFFFF -> results 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF respectively.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MUL 0x80000000 x 0x80000000 -> 0x00000000. MUL 0xFFFFFFFF x 2 -> 0xFFFFFFFE.
- MULHU with op_a=0, op_b=0x12345678 at T -> done at T+1, result=0; stall high only in cycle T.
- MUL 3 x 5 accepted at T, flush at T+10 -> IDLE at T+11, no done pulse, result keeps its prior value. A new MUL 3 x 5 at T+11 -> done at T+44, result=0x0000000F.
- rst asserted mid-CALC -> next cycle state IDLE, result=0, busy=0. start with funct3=100 -> no stall, no done for 40 cycles.

Source files
------------

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU) with pipeline stall control
module mul_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [2*XLEN-1:0]   acc, acc_nxt, p;
    logic [XLEN:0]       sum;
    logic [2:0]          f3;
    logic                neg, accept, sign_a, sign_b;
    assign accept = state == IDLE && start && !funct3[2] && !flush;
    assign stall  = !rst && (accept || state == CALC);
    assign busy   = state != IDLE;
    assign done   = state == DONE;
    assign sign_a = (funct3 == 3'b001 || funct3 == 3'b010) && op_a[XLEN-1];
    assign sign_b = funct3 == 3'b001 && op_b[XLEN-1];
    // one shift-add step: add magnitude into the upper half, keep carry, shift right
    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_b[0] ? mag_a : {XLEN{1'b0}}};
        acc_nxt = {sum, acc[XLEN-1:1]};
        p       = neg ? -acc_nxt : acc_nxt;
    end
    // controller and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            f3     <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mag_a <= sign_a ? -op_a : op_a;
                    mag_b <= sign_b ? -op_b : op_b;
                    neg   <= sign_a ^ sign_b;
                    f3    <= funct3;
                    acc   <= '0;
                    cnt   <= '0;
                    if (op_a == '0 || op_b == '0) begin
                        result <= '0;
                        state  <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: if (flush) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    acc   <= acc_nxt;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) begin
                        result <= f3 == 3'b000 ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed self-checking bench for mul_sequencer
module tb_mul_sequencer;
    logic        clk = 0, rst = 1, start = 0, flush = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] op_a = 0, op_b = 0, result;
    logic        stall, busy, done;
    int          n_chk = 0, n_fail = 0;

    mul_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
        int n, drops;
        funct3 = f; op_a = a; op_b = b; start = 1;
        #1;
        chk({tag, " stall_T"}, stall, 1);
        cyc();
        start = 0;
        n = 1;
        drops = 0;
        while (!done && n < 100) begin
            if (!stall) drops++;
            cyc();
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " stall_gaps"}, drops, 0);
        chk({tag, " stall_at_done"}, stall, 0);
        chk({tag, " result"}, result, exp);
        cyc();
        chk({tag, " done_after"}, done, 0);
        chk({tag, " busy_after"}, busy, 0);
        chk({tag, " stall_after"}, stall, 0);
    endtask

    initial begin
        int bad;
        cyc(); cyc();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst stall", stall, 0);
        rst = 0;
        cyc();
        run("mul_7x6", 3'b000, 32'd7, 32'd6, 32'h0000002A, 33);
        run("mulh_m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run("mulhu_m1", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run("mulhsu_m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run("mul_min", 3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 33);
        run("mul_wrap", 3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
        run("mulh_mix", 3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33);
        run("mulhu_big", 3'b011, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 33);
        run("mulhu_zero", 3'b011, 32'd0, 32'h12345678, 32'd0, 1);
        // flush in IDLE blocks accept
        funct3 = 3'b000; op_a = 3; op_b = 5; start = 1; flush = 1;
        #1;
        chk("idle_flush stall", stall, 0);
        cyc();
        start = 0; flush = 0;
        chk("idle_flush busy", busy, 0);
        // prior result 0xFFFFFFFE, then flush mid-CALC
        run("mul_pre", 3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
        start = 1; op_a = 3; op_b = 5; funct3 = 3'b000;
        cyc();
        start = 0;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (done) bad++;
            cyc();
        end
        flush = 1;
        #1;
        chk("flush stall_in", stall, 1);
        cyc();
        flush = 0;
        chk("flush no_done", bad + int'(done), 0);
        chk("flush busy", busy, 0);
        chk("flush stall", stall, 0);
        chk("flush result", result, 32'hFFFFFFFE);
        run("mul_3x5", 3'b000, 32'd3, 32'd5, 32'h0000000F, 33);
        // reset mid-CALC
        start = 1; op_a = 7; op_b = 6; funct3 = 3'b000;
        cyc();
        start = 0;
        for (int i = 0; i < 5; i++) cyc();
        chk("midrst busy_pre", busy, 1);
        rst = 1;
        cyc();
        chk("midrst busy", busy, 0);
        chk("midrst result", result, 0);
        chk("midrst stall", stall, 0);
        rst = 0;
        // funct3[2]=1 is never accepted
        start = 1; funct3 = 3'b100; op_a = 9; op_b = 9;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall || done || busy) bad++;
            cyc();
        end
        start = 0;
        chk("div_ignored", bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
